// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: two-stage valid/ready pipeline computing a per-bit
// logic function of A and B selected by op.
//   S1 registers the request (A, B, op); S2 registers the result (and flags).
//   Optional feature macro: BITWISE_FLAGS_EN -- when defined, flag_zero and
//   flag_ones are computed from the S2 result and registered alongside it;
//   when undefined they are tied to 0 and no flag logic exists.

// One bit lane: the whole function is bit-sliced, so each lane sees only
// its own A/B bit plus the shared op.
module bitwise_logic_lane (
  input  logic       a,
  input  logic       b,
  input  logic [2:0] op,
  output logic       y
);
  // op decode for a single bit
  always_comb begin
    y = a;
    case (op)
      3'b000: y = a & b;
      3'b001: y = a | b;
      3'b010: y = a ^ b;
      3'b011: y = ~(a | b);
      3'b100: y = ~(a & b);
      3'b101: y = ~(a ^ b);
      3'b110: y = a & ~b;
      3'b111: y = a;
      default: y = a;
    endcase
  end
endmodule

module bitwise_logic_pipe #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_zero,
  output logic             flag_ones
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
  } req_t;

  // vld_pipe[n] is the FULL bit of stage n
  logic [STAGES:1]  vld_pipe;
  req_t             s1_q;
  logic [WIDTH-1:0] s2_res;
  logic [WIDTH-1:0] comp;
  logic             accept;
  logic             s1_move;
  logic             out_xfer;

  // S1 advances when S2 is free now or is being drained this same edge
  assign s1_move  = vld_pipe[1] & (~vld_pipe[2] | out_ready);
  // Held low during reset; never looks at in_valid
  assign in_ready = ~reset & (~vld_pipe[1] | s1_move);
  assign accept   = in_valid & in_ready;
  assign out_xfer = vld_pipe[2] & out_ready;

  // Bit-sliced compute on the S1 operands
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    bitwise_logic_lane u_lane (
      .a  (s1_q.a[i]),
      .b  (s1_q.b[i]),
      .op (s1_q.op),
      .y  (comp[i])
    );
  end

  // Stage 1: capture a new request, or go empty once it moves down
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe[1] <= 1'b0;
      s1_q        <= '0;
    end else if (accept) begin
      vld_pipe[1] <= 1'b1;
      s1_q        <= '{a: A, b: B, op: op};
    end else if (s1_move) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  // Stage 2: load on S1 move (stays FULL if draining at the same time)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_pipe[2] <= 1'b0;
      s2_res      <= '0;
    end else if (s1_move) begin
      vld_pipe[2] <= 1'b1;
      s2_res      <= comp;
    end else if (out_xfer) begin
      vld_pipe[2] <= 1'b0;
    end
  end

  assign out_valid = vld_pipe[2];
  assign result    = s2_res;

`ifdef BITWISE_FLAGS_EN
  logic fz_q, fo_q;

  // Flags ride in S2 with the result they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fz_q <= 1'b0;
      fo_q <= 1'b0;
    end else if (s1_move) begin
      fz_q <= (comp == '0);
      fo_q <= (comp == '1);
    end
  end

  assign flag_zero = fz_q;
  assign flag_ones = fo_q;
`else
  assign flag_zero = 1'b0;
  assign flag_ones = 1'b0;
`endif

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Self-checking bench for bitwise_logic_pipe: vector table through a
// scoreboard, plus hand sequences for latency, backpressure, reset and
// the 8-bit configuration.
module tb_bitwise_logic_pipe;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] A, B, result;
  logic [2:0]  op;
  logic        flag_zero, flag_ones;

  logic        in_valid8, in_ready8, out_valid8, out_ready8;
  logic [7:0]  a8, b8, result8;
  logic [2:0]  op8;
  logic        fz8, fo8;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int stalls     = 0;
  logic [33:0] sb[$];
  int          pop_cyc[$];

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [31:0] exp;
  } vec_t;
  vec_t vt[12];

  bitwise_logic_pipe #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .op(op), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flag_zero(flag_zero), .flag_ones(flag_ones)
  );

  bitwise_logic_pipe #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .op(op8), .out_valid(out_valid8), .out_ready(out_ready8),
    .result(result8), .flag_zero(fz8), .flag_ones(fo8)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [31:0] a, b, input logic [2:0] o);
    case (o)
      3'd0: return a & b;
      3'd1: return a | b;
      3'd2: return a ^ b;
      3'd3: return ~(a | b);
      3'd4: return ~(a & b);
      3'd5: return ~(a ^ b);
      3'd6: return a & ~b;
      default: return a;
    endcase
  endfunction

  function automatic logic [33:0] with_flags(input logic [31:0] r);
`ifdef BITWISE_FLAGS_EN
    return {r == 32'h0, r == 32'hFFFF_FFFF, r};
`else
    return {2'b00, r};
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard consumer: every output transfer pops and compares
  always @(negedge clock) begin
    if (out_valid && out_ready && !reset) begin
      if (sb.size() == 0) chk("unexpected_output", {30'd0, flag_zero, flag_ones, result}, 64'hDEAD);
      else begin
        chk("sb_result", {30'd0, flag_zero, flag_ones, result}, {30'd0, sb.pop_front()});
        pop_cyc.push_back(cyc);
      end
    end
  end

  // Present one request; returns just after the accepting edge
  task automatic send(input logic [31:0] a, b, input logic [2:0] o, input logic [31:0] exp);
    int waits = 0;
    A = a; B = b; op = o; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waits < 200) begin
      @(negedge clock);
      waits++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    else sb.push_back(with_flags(exp));
    stalls += waits;
    @(posedge clock); #1;
    in_valid = 1'b0;
    A = $urandom; B = $urandom; op = 3'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clock); #1;
  endtask

  initial begin
    logic [31:0] hold;
    int gaps, stale;
    logic bp_done;

    vt[0]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd0, 32'hF000F000};
    vt[1]  = '{32'h0000FFFF, 32'h00FF00FF, 3'd1, 32'h00FFFFFF};
    vt[2]  = '{32'h0000FFFF, 32'h00FF00FF, 3'd2, 32'h00FFFF00};
    vt[3]  = '{32'h0000FFFF, 32'h00FF00FF, 3'd3, 32'hFF000000};
    vt[4]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd4, 32'h0FFF0FFF};
    vt[5]  = '{32'hF0F0F0F0, 32'hFF00FF00, 3'd5, 32'hF00FF00F};
    vt[6]  = '{32'hAAAAAAAA, 32'h0F0F0F0F, 3'd6, 32'hA0A0A0A0};
    vt[7]  = '{32'h12345678, 32'hFFFFFFFF, 3'd7, 32'h12345678};
    vt[8]  = '{32'h12345678, 32'h12345678, 3'd2, 32'h00000000};
    vt[9]  = '{32'h00000000, 32'h00000000, 3'd3, 32'hFFFFFFFF};
    vt[10] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF};
    vt[11] = '{32'h00000000, 32'h00000000, 3'd1, 32'h00000000};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; op = '0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; a8 = '0; b8 = '0; op8 = '0;

    // Reset state
    repeat (2) @(negedge clock);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_result", 64'(result), 64'd0);
    chk("rst_flags", {62'd0, flag_zero, flag_ones}, 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clock); #1;

    // Two-cycle latency for a single request
    A = 32'hF0F0F0F0; B = 32'hFF00FF00; op = 3'd0; in_valid = 1'b1;
    @(negedge clock);
    chk("lat_in_ready", 64'(in_ready), 64'd1);
    sb.push_back(with_flags(32'hF000F000));
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(negedge clock);
    chk("lat_cycle1_valid", 64'(out_valid), 64'd0);
    @(negedge clock);
    chk("lat_cycle2_valid", 64'(out_valid), 64'd1);
    chk("lat_cycle2_result", 64'(result), 64'hF000F000);
    drain();

    // Table streamed back-to-back: full throughput, in order
    pop_cyc.delete();
    stalls = 0;
    for (int i = 0; i < 12; i++) send(vt[i].a, vt[i].b, vt[i].op, vt[i].exp);
    drain();
    gaps = 0;
    for (int i = 1; i < pop_cyc.size(); i++) if (pop_cyc[i] != pop_cyc[i-1] + 1) gaps++;
    chk("stream_pops", 64'(pop_cyc.size()), 64'd12);
    chk("stream_out_gaps", 64'(gaps), 64'd0);
    chk("stream_in_stalls", 64'(stalls), 64'd0);

    // Backpressure: third request must stall, output must hold
    out_ready = 1'b0;
    fork
      begin
        send(32'h11111111, 32'h0000FFFF, 3'd1, 32'h1111FFFF);
        send(32'h22222222, 32'h22220000, 3'd2, 32'h00002222);
        send(32'h33333333, 32'h0F0F0F0F, 3'd6, 32'h30303030);
      end
      begin
        repeat (4) @(negedge clock);
        chk("bp_in_ready_low", 64'(in_ready), 64'd0);
        chk("bp_out_valid", 64'(out_valid), 64'd1);
        hold = result;
        chk("bp_first_result", 64'(result), 64'h1111FFFF);
        repeat (3) @(negedge clock);
        chk("bp_result_stable", 64'(result), 64'(hold));
        chk("bp_valid_stable", 64'(out_valid), 64'd1);
        chk("bp_still_blocked", 64'(in_ready), 64'd0);
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random backpressure against the model
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          logic [31:0] ra, rb;
          logic [2:0]  ro;
          ra = $urandom; rb = $urandom; ro = 3'($urandom);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clock); #1;
          end
          send(ra, rb, ro, model(ra, rb, ro));
        end
        bp_done = 1'b1;
      end
      begin
        while (!bp_done) begin
          @(posedge clock); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // 8-bit build: A AND NOT B, then pass A
    a8 = 8'hAA; b8 = 8'h0F; op8 = 3'd6; in_valid8 = 1'b1;
    @(posedge clock); #1;
    op8 = 3'd7;
    @(posedge clock); #1;
    in_valid8 = 1'b0;
    @(negedge clock);
    chk("w8_andn_valid", 64'(out_valid8), 64'd1);
    chk("w8_andn", 64'(result8), 64'hA0);
    @(negedge clock);
    chk("w8_pass_valid", 64'(out_valid8), 64'd1);
    chk("w8_pass", 64'(result8), 64'hAA);
    @(posedge clock); #1;

    // Reset mid-cycle with both stages full
    out_ready = 1'b0;
    send(32'hCAFEF00D, 32'h0, 3'd1, 32'hCAFEF00D);
    send(32'h12345678, 32'h0, 3'd7, 32'h12345678);
    #1;
    reset = 1'b1;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_result", 64'(result), 64'd0);
    chk("arst_flags", {62'd0, flag_zero, flag_ones}, 64'd0);
    chk("arst_in_ready", 64'(in_ready), 64'd0);
    sb.delete();
    @(posedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    chk("arst_release_in_ready", 64'(in_ready), 64'd1);
    stale = 0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) stale++;
    end
    chk("arst_no_stale", 64'(stale), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/bitwise_logic_pipe.md
BITWISE_LOGIC_PIPE -- requirements
Module: bitwise_logic_pipe

Interface
REQ-001 Parameter: WIDTH, 32, operand and result width in bits; SHALL be legal for any value 1..64.
REQ-002 Port: clock  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  high when A, B and op hold a request.
REQ-005 Port: in_ready  output  1  high when the block accepts a request this cycle.
REQ-006 Port: A  input  WIDTH  first operand.
REQ-007 Port: B  input  WIDTH  second operand.
REQ-008 Port: op  input  3  operation select.
REQ-009 Port: out_valid  output  1  high while result holds an unconsumed result.
REQ-010 Port: out_ready  input  1  high when the consumer takes the result this cycle.
REQ-011 Port: result  output  WIDTH  bitwise result.
REQ-012 Port: flag_zero  output  1  result is all zeros (see Configuration).
REQ-013 Port: flag_ones  output  1  result is all ones (see Configuration).

Function
REQ-014 op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NOR, 100 NAND, 101 XNOR, 110 A AND NOT B, 111 pass A.
REQ-015 Each result bit i SHALL depend only on A[i], B[i] and op; no carries, shifts or cross-bit terms.
REQ-016 Transfer in SHALL occur on a rising edge where in_valid and in_ready are both high; transfer out where out_valid and out_ready are both high.
REQ-017 Datapath SHALL be two register stages: S1 captures A, B, op; S2 captures the computed result (and flags).
REQ-018 Per stage, state SHALL be EMPTY or FULL; S2 EMPTY->FULL when S1 FULL moves down; S2 FULL->EMPTY on transfer out with no S1 move; S2 stays FULL when both happen the same cycle.
REQ-019 S1 SHALL move to S2 when S1 FULL and (S2 EMPTY or out_ready high).
REQ-020 in_ready SHALL equal (S1 EMPTY) or (S1 moves this cycle); combinational from out_ready is allowed, from in_valid is not.
REQ-021 Latency SHALL be exactly 2 cycles from accept to out_valid with no backpressure; sustained throughput SHALL be 1 result per cycle.
REQ-022 With out_ready low and both stages FULL, in_ready SHALL be low and result, flags, out_valid SHALL hold stable.
REQ-023 Results SHALL leave in acceptance order; no request SHALL be dropped or duplicated.
REQ-024 A, B, op SHALL be ignored when not transferring in; out_ready SHALL be ignored while out_valid is low.
REQ-025 result SHALL be driven from the S2 register only, never combinationally from inputs.

Reset
REQ-026 Asserting reset SHALL immediately, independent of clock, clear both stages to EMPTY and drive out_valid 0, result 0, flag_zero 0, flag_ones 0.
REQ-027 in_ready SHALL be 0 while reset is high and 1 on the first cycle after deassertion.
REQ-028 Requests in flight when reset asserts SHALL be discarded; no result from them SHALL appear after reset.

Configuration
REQ-029 Macro BITWISE_FLAGS_EN: when defined, flag_zero and flag_ones SHALL be computed from the S2 result and registered with it.
REQ-030 Without BITWISE_FLAGS_EN, flag_zero and flag_ones SHALL be constant 0 and no flag logic SHALL be synthesised; all other behaviour identical.

Verification
REQ-031 WIDTH=32, out_ready=1, accept A=F0F0F0F0 B=FF00FF00 op=000 -> 2 cycles later out_valid=1, result=F000F000.
REQ-032 Back-to-back ops 001,010,011 on A=0000FFFF B=00FF00FF, out_ready=1 -> results 00FFFFFF, 00FFFF00, FF000000 on three consecutive cycles.
REQ-033 out_ready=0, issue 3 requests -> 2 accepted, in_ready low on third, result stable; raise out_ready -> all 3 emerge in order, none lost.
REQ-034 With BITWISE_FLAGS_EN, op=010 A=B=12345678 -> result 0, flag_zero=1; op=011 A=B=0 -> result FFFFFFFF, flag_ones=1; without macro both flags stay 0.
REQ-035 Assert reset mid-clock with both stages FULL -> out_valid, result 0 at once; after release in_ready=1 and no stale result appears.
REQ-036 WIDTH=8, op=110 A=AA B=0F -> result A0; op=111 -> result equals A.
